// File: rtl/byte_align_pkg.sv
`default_nettype none
// ============================================================================
// Module      : byte_align_pkg
// Description : Shared definitions for the byte-lane align controller:
//               FSM state encodings, maximum delay select and the default
//               training/sync word.
// Revision    : 1.0 - initial release
// ============================================================================
package byte_align_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_SET    = 3'd1;
    localparam state_t ST_SETTLE = 3'd2;
    localparam state_t ST_CHECK  = 3'd3;
    localparam state_t ST_LOCKED = 3'd4;

    // Largest legal byte-shift select; the sweep wraps from here back to 0.
    localparam logic [2:0]  DLY_MAX       = 3'd4;
    localparam logic [31:0] SYNC_WORD_DEF = 32'hBC50_BC50;

endpackage
`default_nettype wire

// File: rtl/align_win_cnt.sv
`default_nettype none
// ============================================================================
// Module      : align_win_cnt
// Description : Observation-window timer plus saturating hit counter.
//               While run is high it counts WIN_LEN-cycle windows; win_end
//               flags the last cycle of each window. hits_ok / zero_hits
//               include the hit presented on the current cycle, so a hit on
//               the final window cycle still counts. Both counters restart
//               after every window end and whenever run is low.
// Ports       : clk, rst_n (async, active low), run, hit
//               -> win_end, hits_ok, zero_hits
// Revision    : 1.0 - initial release
// ============================================================================
module align_win_cnt #(
    parameter int WIN_LEN  = 64,
    parameter int LOCK_THR = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic hit,
    output logic win_end,
    output logic hits_ok,
    output logic zero_hits
);

    localparam int              c_ww       = $clog2(WIN_LEN + 1);
    localparam int              c_hw       = $clog2(LOCK_THR + 1);
    localparam logic [c_ww-1:0] c_win_last = c_ww'(WIN_LEN - 1);
    localparam logic [c_hw-1:0] c_hit_max  = c_hw'(LOCK_THR);

    logic [c_ww-1:0] r_win_cnt;
    logic [c_hw-1:0] r_hit_cnt;
    logic [c_hw:0]   w_hit_sum;

    // One extra bit so the saturated count plus a fresh hit cannot wrap.
    assign w_hit_sum = (c_hw + 1)'(r_hit_cnt) + (c_hw + 1)'(hit);
    assign win_end   = run && (r_win_cnt == c_win_last);
    assign hits_ok   = (w_hit_sum >= (c_hw + 1)'(c_hit_max));
    assign zero_hits = (w_hit_sum == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win_cnt <= '0;
            r_hit_cnt <= '0;
        end else if (!run || win_end) begin
            r_win_cnt <= '0;
            r_hit_cnt <= '0;
        end else begin
            r_win_cnt <= r_win_cnt + c_ww'(1);
            if (r_hit_cnt != c_hit_max) begin
                r_hit_cnt <= r_hit_cnt + c_hw'(hit);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/byte_align_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : byte_align_ctrl
// Description : Search/lock controller for the 32-bit byte-lane aligner.
//               Sweeps delay_time 0..4, letting the aligner settle after
//               each change, and locks on the first delay whose observation
//               window sees enough SYNC_WORD hits. While locked it watches
//               for consecutive empty windows and falls back to CHECK at the
//               same delay when lock is lost.
// Ports       : clk, rst_n (async, active low), en, realign, aligned_data[31:0]
//               -> delay_time[2:0], locked, search_fail, state_dbg[2:0]
//               [err_cnt[15:0] when ALIGN_ERR_CNT_EN is defined]
// Options     : ALIGN_ERR_CNT_EN - adds a saturating error counter that
//               counts lock losses and failed sweeps; cleared by realign.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_align_ctrl
    import byte_align_pkg::*;
#(
    parameter logic [31:0] SYNC_WORD  = SYNC_WORD_DEF,
    parameter int          SETTLE_CYC = 3,
    parameter int          WIN_LEN    = 64,
    parameter int          LOCK_THR   = 4,
    parameter int          UNLOCK_THR = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        realign,
    input  logic [31:0] aligned_data,
    output logic [2:0]  delay_time,
    output logic        locked,
    output logic        search_fail,
`ifdef ALIGN_ERR_CNT_EN
    output logic [15:0] err_cnt,
`endif
    output logic [2:0]  state_dbg
);

    localparam int              c_sw          = $clog2(SETTLE_CYC + 1);
    localparam logic [c_sw-1:0] c_settle_last = c_sw'(SETTLE_CYC - 1);
    localparam int              c_mw          = $clog2(UNLOCK_THR + 1);
    localparam logic [c_mw-1:0] c_miss_last   = c_mw'(UNLOCK_THR - 1);

    state_t          r_state;
    logic [2:0]      r_dly;
    logic            r_locked;
    logic            r_fail;
    logic [c_sw-1:0] r_settle_cnt;
    logic [c_mw-1:0] r_miss_cnt;

    logic w_hit;
    logic w_run;
    logic w_win_end;
    logic w_hits_ok;
    logic w_zero_hits;

    assign w_hit = (aligned_data == SYNC_WORD);
    // Window counters only run while the aligned word is being judged;
    // every other state holds them cleared so CHECK starts from zero.
    assign w_run = (r_state == ST_CHECK) || (r_state == ST_LOCKED);

    align_win_cnt #(
        .WIN_LEN  (WIN_LEN),
        .LOCK_THR (LOCK_THR)
    ) u_win_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (w_run),
        .hit       (w_hit),
        .win_end   (w_win_end),
        .hits_ok   (w_hits_ok),
        .zero_hits (w_zero_hits)
    );

`ifdef ALIGN_ERR_CNT_EN
    logic [15:0] r_err_cnt;
    assign err_cnt = r_err_cnt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_dly        <= '0;
            r_locked     <= 1'b0;
            r_fail       <= 1'b0;
            r_settle_cnt <= '0;
            r_miss_cnt   <= '0;
`ifdef ALIGN_ERR_CNT_EN
            r_err_cnt    <= '0;
`endif
        end else begin
            r_fail <= 1'b0;
            if (!en) begin
                // Disable parks the FSM but keeps the last delay applied.
                r_state  <= ST_IDLE;
                r_locked <= 1'b0;
            end else if (realign) begin
                r_state    <= ST_SET;
                r_dly      <= '0;
                r_locked   <= 1'b0;
                r_miss_cnt <= '0;
`ifdef ALIGN_ERR_CNT_EN
                r_err_cnt  <= '0;
`endif
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_SET;
                        r_dly   <= '0;
                    end
                    ST_SET: begin
                        r_state      <= ST_SETTLE;
                        r_settle_cnt <= '0;
                    end
                    ST_SETTLE: begin
                        if (r_settle_cnt == c_settle_last) begin
                            r_state <= ST_CHECK;
                        end else begin
                            r_settle_cnt <= r_settle_cnt + c_sw'(1);
                        end
                    end
                    ST_CHECK: begin
                        if (w_win_end) begin
                            if (w_hits_ok) begin
                                r_state    <= ST_LOCKED;
                                r_locked   <= 1'b1;
                                r_miss_cnt <= '0;
                            end else begin
                                r_state <= ST_SET;
                                if (r_dly == DLY_MAX) begin
                                    r_dly  <= '0;
                                    r_fail <= 1'b1;
`ifdef ALIGN_ERR_CNT_EN
                                    if (r_err_cnt != 16'hFFFF) begin
                                        r_err_cnt <= r_err_cnt + 16'd1;
                                    end
`endif
                                end else begin
                                    r_dly <= r_dly + 3'd1;
                                end
                            end
                        end
                    end
                    ST_LOCKED: begin
                        if (w_win_end) begin
                            if (w_zero_hits) begin
                                if (r_miss_cnt == c_miss_last) begin
                                    r_state    <= ST_CHECK;
                                    r_locked   <= 1'b0;
                                    r_miss_cnt <= '0;
`ifdef ALIGN_ERR_CNT_EN
                                    if (r_err_cnt != 16'hFFFF) begin
                                        r_err_cnt <= r_err_cnt + 16'd1;
                                    end
`endif
                                end else begin
                                    r_miss_cnt <= r_miss_cnt + c_mw'(1);
                                end
                            end else begin
                                r_miss_cnt <= '0;
                            end
                        end
                    end
                    default: begin
                        r_state  <= ST_IDLE;
                        r_locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign delay_time  = r_dly;
    assign locked      = r_locked;
    assign search_fail = r_fail;
    assign state_dbg   = r_state;

endmodule
`default_nettype wire
